// File: rtl/bulls_cows_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bulls_cows_pkg : shared constants, states and scoring helpers. Rev 1.0
// ---------------------------------------------------------------------------
package bulls_cows_pkg;

  localparam int DIGIT_W = 4;
  localparam int GUESS_W = 8;

  localparam logic [2:0] SCORE_TWO  = 3'b100;
  localparam logic [2:0] SCORE_ONE  = 3'b010;
  localparam logic [2:0] SCORE_NONE = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_WAIT_FB = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAIL    = 3'd4
  } state_t;

  function automatic logic [2:0] encode_score(input logic m0, input logic m1);
    logic [2:0] s;
    case ({m0, m1})
      2'b11:   s = SCORE_TWO;
      2'b00:   s = SCORE_NONE;
      default: s = SCORE_ONE;
    endcase
    return s;
  endfunction

  function automatic logic is_score(input logic [2:0] v);
    return (v == SCORE_TWO) || (v == SCORE_ONE) || (v == SCORE_NONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bc_score.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bc_score : combinational one-hot bulls/cows scorer for 2-digit codes. Rev 1.0
// ---------------------------------------------------------------------------
module bc_score
  import bulls_cows_pkg::*;
(
  input  logic [GUESS_W-1:0] a,
  input  logic [GUESS_W-1:0] b,
  output logic [2:0]         bulls,
  output logic [2:0]         cows
);

  logic [DIGIT_W-1:0] a_hi, a_lo, b_hi, b_lo;

  assign a_hi = a[GUESS_W-1:DIGIT_W];
  assign a_lo = a[DIGIT_W-1:0];
  assign b_hi = b[GUESS_W-1:DIGIT_W];
  assign b_lo = b[DIGIT_W-1:0];

  // Cows are the crossed-position matches, so the rule is symmetric in a/b.
  assign bulls = encode_score(a_hi == b_hi, a_lo == b_lo);
  assign cows  = encode_score(a_hi == b_lo, a_lo == b_hi);

endmodule
`default_nettype wire

// File: rtl/bulls_cows_solver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bulls_cows_solver : consistent-candidate code-breaker for 2-digit game. Rev 1.0
// ---------------------------------------------------------------------------
module bulls_cows_solver
  import bulls_cows_pkg::*;
#(
  parameter int DIGIT_MAX   = 9,
  parameter int MAX_GUESSES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [GUESS_W-1:0] guess,
  output logic               guess_valid,
  input  logic               fb_valid,
  input  logic [2:0]         fb_bulls,
  input  logic [2:0]         fb_cows,
  output logic               busy,
  output logic               solved,
  output logic               fail,
  output logic [3:0]         guess_count
);

  localparam int CNT_W = $clog2(MAX_GUESSES + 1);
  localparam int IDX_W = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
  localparam logic [DIGIT_W-1:0] DMAX      = DIGIT_W'(DIGIT_MAX);
  localparam logic [CNT_W-1:0]   HIST_FULL = CNT_W'(MAX_GUESSES);

  state_t             state_q;
  logic [GUESS_W-1:0] cand_q, guess_q;
  logic [CNT_W-1:0]   idx_q, hcnt_q;
  logic [3:0]         gcnt_q;
  logic               gv_q, busy_q, solved_q, fail_q, start_q;
  logic [13:0]        hist_q [MAX_GUESSES];

  logic [13:0]        entry;
  logic [2:0]         sc_bulls, sc_cows;
  logic               entry_match, cand_last, fb_ok, hist_we;
  logic [GUESS_W-1:0] cand_next;

  assign entry       = hist_q[idx_q[IDX_W-1:0]];
  assign entry_match = ({sc_bulls, sc_cows} == entry[5:0]);
  assign cand_last   = (cand_q == {DMAX, DMAX});
  assign cand_next   = (cand_q[DIGIT_W-1:0] == DMAX) ?
                       {cand_q[GUESS_W-1:DIGIT_W] + 4'd1, 4'd0} :
                       {cand_q[GUESS_W-1:DIGIT_W], cand_q[DIGIT_W-1:0] + 4'd1};
  assign fb_ok       = is_score(fb_bulls) && is_score(fb_cows);
  assign hist_we     = rst_n && (state_q == ST_WAIT_FB) && fb_valid && fb_ok &&
                       (fb_bulls != SCORE_TWO);

  bc_score u_score (
    .a     (cand_q),
    .b     (entry[13:6]),
    .bulls (sc_bulls),
    .cows  (sc_cows)
  );

  always_ff @(posedge clk) begin
    if (hist_we) hist_q[hcnt_q[IDX_W-1:0]] <= {guess_q, fb_bulls, fb_cows};
  end

  // start is captured one cycle before the FSM acts on it, giving the
  // two-edge start-to-first-guess latency; a start seen while busy is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      cand_q   <= '0;
      guess_q  <= '0;
      idx_q    <= '0;
      hcnt_q   <= '0;
      gcnt_q   <= '0;
      gv_q     <= 1'b0;
      busy_q   <= 1'b0;
      solved_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      start_q <= start && !busy_q;
      case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start_q) begin
            hcnt_q   <= '0;
            gcnt_q   <= '0;
            idx_q    <= '0;
            cand_q   <= '0;
            solved_q <= 1'b0;
            fail_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (idx_q == hcnt_q) begin
            guess_q <= cand_q;
            gv_q    <= 1'b1;
            gcnt_q  <= gcnt_q + 4'd1;
            state_q <= ST_WAIT_FB;
          end else if (entry_match) begin
            idx_q <= idx_q + CNT_W'(1);
          end else if (cand_last) begin
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_FAIL;
          end else begin
            cand_q <= cand_next;
            idx_q  <= '0;
          end
        end
        ST_WAIT_FB: begin
          if (fb_valid) begin
            gv_q <= 1'b0;
            if (!fb_ok) begin
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_FAIL;
            end else if (fb_bulls == SCORE_TWO) begin
              solved_q <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= ST_DONE;
            end else begin
              hcnt_q <= hcnt_q + CNT_W'(1);
              idx_q  <= '0;
              if ((hcnt_q + CNT_W'(1) == HIST_FULL) || cand_last) begin
                fail_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_FAIL;
              end else begin
                cand_q  <= cand_next;
                state_q <= ST_CHECK;
              end
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          gv_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign guess       = guess_q;
  assign guess_valid = gv_q;
  assign busy        = busy_q;
  assign solved      = solved_q;
  assign fail        = fail_q;
  assign guess_count = gcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bulls_cows_solver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bulls_cows_solver : directed bench over three parameterisations. Rev 1.0
// ---------------------------------------------------------------------------
module tb_bulls_cows_solver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a [3];
  logic       fbv_a   [3];
  logic [2:0] fbb_a   [3];
  logic [2:0] fbc_a   [3];
  logic [7:0] guess_a [3];
  logic       gv_a    [3];
  logic       busy_a  [3];
  logic       solved_a[3];
  logic       fail_a  [3];
  logic [3:0] gcnt_a  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0: default game, u1: two-valued digits, u2: two-guess history.
  bulls_cows_solver #(.DIGIT_MAX(9), .MAX_GUESSES(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .guess(guess_a[0]),
    .guess_valid(gv_a[0]), .fb_valid(fbv_a[0]), .fb_bulls(fbb_a[0]),
    .fb_cows(fbc_a[0]), .busy(busy_a[0]), .solved(solved_a[0]),
    .fail(fail_a[0]), .guess_count(gcnt_a[0]));
  bulls_cows_solver #(.DIGIT_MAX(1), .MAX_GUESSES(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .guess(guess_a[1]),
    .guess_valid(gv_a[1]), .fb_valid(fbv_a[1]), .fb_bulls(fbb_a[1]),
    .fb_cows(fbc_a[1]), .busy(busy_a[1]), .solved(solved_a[1]),
    .fail(fail_a[1]), .guess_count(gcnt_a[1]));
  bulls_cows_solver #(.DIGIT_MAX(9), .MAX_GUESSES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_a[2]), .guess(guess_a[2]),
    .guess_valid(gv_a[2]), .fb_valid(fbv_a[2]), .fb_bulls(fbb_a[2]),
    .fb_cows(fbc_a[2]), .busy(busy_a[2]), .solved(solved_a[2]),
    .fail(fail_a[2]), .guess_count(gcnt_a[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int u);
    start_a[u] = 1'b1;
    tick();
    start_a[u] = 1'b0;
  endtask

  task automatic wait_guess(input int u, input string tag);
    int n = 0;
    while (!gv_a[u] && n < 3000) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, 32'(gv_a[u]), 32'd1);
  endtask

  task automatic give_fb(input int u, input logic [2:0] b, input logic [2:0] c);
    fbv_a[u] = 1'b1;
    fbb_a[u] = b;
    fbc_a[u] = c;
    tick();
    fbv_a[u] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0;
      fbv_a[i]   = 1'b0;
      fbb_a[i]   = 3'b001;
      fbc_a[i]   = 3'b001;
    end
    tick();
    tick();
    rst_n = 1'b1;
    check_eq("rst_guess",  32'(guess_a[0]),  32'h00);
    check_eq("rst_gv",     32'(gv_a[0]),     32'd0);
    check_eq("rst_busy",   32'(busy_a[0]),   32'd0);
    check_eq("rst_solved", 32'(solved_a[0]), 32'd0);
    check_eq("rst_fail",   32'(fail_a[0]),   32'd0);
    check_eq("rst_gcnt",   32'(gcnt_a[0]),   32'd0);

    // Secret 0x00: first guess two edges after start, solved immediately.
    pulse_start(0);
    check_eq("lat_k",   32'(gv_a[0]), 32'd0);
    tick();
    check_eq("lat_k1",  32'(gv_a[0]), 32'd0);
    tick();
    check_eq("lat_k2",  32'(gv_a[0]), 32'd1);
    check_eq("s00_g",   32'(guess_a[0]), 32'h00);
    check_eq("s00_busy", 32'(busy_a[0]), 32'd1);
    give_fb(0, 3'b100, 3'b100);
    check_eq("s00_solved", 32'(solved_a[0]), 32'd1);
    check_eq("s00_gcnt",   32'(gcnt_a[0]),   32'd1);
    check_eq("s00_busy0",  32'(busy_a[0]),   32'd0);
    check_eq("s00_gv0",    32'(gv_a[0]),     32'd0);
    tick();
    check_eq("s00_hold_g", 32'(guess_a[0]),  32'h00);

    // Secret 0x12: 00 -> 001/001, 11 -> 010/010, 12 -> 100/001.
    pulse_start(0);
    wait_guess(0, "s12_g1");
    check_eq("s12_g1", 32'(guess_a[0]), 32'h00);
    give_fb(0, 3'b001, 3'b001);
    wait_guess(0, "s12_g2");
    check_eq("s12_g2", 32'(guess_a[0]), 32'h11);
    give_fb(0, 3'b010, 3'b010);
    wait_guess(0, "s12_g3");
    check_eq("s12_g3", 32'(guess_a[0]), 32'h12);
    give_fb(0, 3'b100, 3'b001);
    check_eq("s12_solved", 32'(solved_a[0]), 32'd1);
    check_eq("s12_gcnt",   32'(gcnt_a[0]),   32'd3);

    // DIGIT_MAX=1: only 11 survives 00->001/001, then nothing remains.
    pulse_start(1);
    wait_guess(1, "dm1_g1");
    check_eq("dm1_g1", 32'(guess_a[1]), 32'h00);
    give_fb(1, 3'b001, 3'b001);
    wait_guess(1, "dm1_g2");
    check_eq("dm1_g2",   32'(guess_a[1]), 32'h11);
    check_eq("dm1_gc2",  32'(gcnt_a[1]),  32'd2);
    give_fb(1, 3'b001, 3'b001);
    check_eq("dm1_fail", 32'(fail_a[1]),  32'd1);
    check_eq("dm1_gv",   32'(gv_a[1]),    32'd0);
    check_eq("dm1_busy", 32'(busy_a[1]),  32'd0);
    check_eq("dm1_gcnt", 32'(gcnt_a[1]),  32'd2);

    // MAX_GUESSES=2, secret 0x99: history fills on the second answer.
    pulse_start(2);
    wait_guess(2, "mg_g1");
    check_eq("mg_g1", 32'(guess_a[2]), 32'h00);
    give_fb(2, 3'b001, 3'b001);
    wait_guess(2, "mg_g2");
    check_eq("mg_g2", 32'(guess_a[2]), 32'h11);
    give_fb(2, 3'b001, 3'b001);
    check_eq("mg_fail", 32'(fail_a[2]), 32'd1);
    check_eq("mg_gv",   32'(gv_a[2]),   32'd0);
    give_fb(2, 3'b100, 3'b100);
    tick();
    check_eq("mg_fail_hold", 32'(fail_a[2]),   32'd1);
    check_eq("mg_no_solve",  32'(solved_a[2]), 32'd0);
    check_eq("mg_gcnt",      32'(gcnt_a[2]),   32'd2);

    // Malformed one-hot feedback aborts the game.
    pulse_start(0);
    wait_guess(0, "inv_g");
    give_fb(0, 3'b011, 3'b001);
    check_eq("inv_fail",   32'(fail_a[0]),   32'd1);
    check_eq("inv_gv",     32'(gv_a[0]),     32'd0);
    check_eq("inv_solved", 32'(solved_a[0]), 32'd0);

    // Reset in the middle of a handshake.
    pulse_start(0);
    wait_guess(0, "mid_g");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("mid_gv",    32'(gv_a[0]),    32'd0);
    check_eq("mid_busy",  32'(busy_a[0]),  32'd0);
    check_eq("mid_gcnt",  32'(gcnt_a[0]),  32'd0);
    check_eq("mid_guess", 32'(guess_a[0]), 32'h00);

    // Start while busy is ignored.
    pulse_start(0);
    wait_guess(0, "busy_g");
    pulse_start(0);
    tick();
    tick();
    tick();
    check_eq("busy_gcnt",  32'(gcnt_a[0]),  32'd1);
    check_eq("busy_gv",    32'(gv_a[0]),    32'd1);
    check_eq("busy_guess", 32'(guess_a[0]), 32'h00);
    check_eq("busy_busy",  32'(busy_a[0]),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
